// File: rtl/rocketcpu_codec_pkg.sv
// -----------------------------------------------------------------------------
// rocketcpu_codec_pkg
// Shared definitions for the audio-codec init sequencer: the FSM state
// encoding, the codec register addresses used to build 16-bit control words
// {addr[6:0], data[8:0]}, the default table length and the default table.
// -----------------------------------------------------------------------------
package rocketcpu_codec_pkg;

    localparam int DEFAULT_NWORDS = 11;

    // Codec register addresses (7-bit field of the control word).
    localparam logic [6:0] ADDR_LINVOL  = 7'h00;
    localparam logic [6:0] ADDR_RINVOL  = 7'h01;
    localparam logic [6:0] ADDR_LHPOUT  = 7'h02;
    localparam logic [6:0] ADDR_RHPOUT  = 7'h03;
    localparam logic [6:0] ADDR_ANALOG  = 7'h04;
    localparam logic [6:0] ADDR_DIGITAL = 7'h05;
    localparam logic [6:0] ADDR_PWR     = 7'h06;
    localparam logic [6:0] ADDR_IFACE   = 7'h07;
    localparam logic [6:0] ADDR_SRATE   = 7'h08;
    localparam logic [6:0] ADDR_ACTIVE  = 7'h09;
    localparam logic [6:0] ADDR_RESET   = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_LOAD,
        ST_WRITE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } codec_state_e;

    function automatic logic [15:0] ctrlWord(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

    // Default bring-up table: reset first, activate last, everything in
    // between configures power, volumes, analog/digital paths and format.
    function automatic logic [15:0] defaultWord(input logic [31:0] idx);
        logic [15:0] w;
        case (idx)
            32'd0:   w = ctrlWord(ADDR_RESET,   9'h000);
            32'd1:   w = ctrlWord(ADDR_PWR,     9'h010);
            32'd2:   w = ctrlWord(ADDR_LINVOL,  9'h017);
            32'd3:   w = ctrlWord(ADDR_RINVOL,  9'h017);
            32'd4:   w = ctrlWord(ADDR_LHPOUT,  9'h079);
            32'd5:   w = ctrlWord(ADDR_RHPOUT,  9'h079);
            32'd6:   w = ctrlWord(ADDR_ANALOG,  9'h012);
            32'd7:   w = ctrlWord(ADDR_DIGITAL, 9'h000);
            32'd8:   w = ctrlWord(ADDR_IFACE,   9'h00A);
            32'd9:   w = ctrlWord(ADDR_SRATE,   9'h000);
            32'd10:  w = ctrlWord(ADDR_ACTIVE,  9'h001);
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rocketcpu_codec_init_rom.sv
// -----------------------------------------------------------------------------
// rocketcpu_codec_init_rom
// Combinational table of NWORDS codec control words.
//   index_i : word index (IDXW bits)
//   word_o  : control word {addr[6:0], data[8:0]}; zero for out-of-range index
// -----------------------------------------------------------------------------
module rocketcpu_codec_init_rom
    import rocketcpu_codec_pkg::*;
#(
    parameter int NWORDS = DEFAULT_NWORDS,
    parameter int IDXW   = 4
) (
    input  logic [IDXW-1:0] index_i,
    output logic [15:0]     word_o
);

    logic [31:0] idxWide;

    assign idxWide = 32'(index_i);

    always_comb begin
        word_o = 16'h0000;
        if (idxWide < 32'(NWORDS)) begin
            word_o = defaultWord(idxWide);
        end
    end

endmodule

// File: rtl/rocketcpu_codec_init.sv
// -----------------------------------------------------------------------------
// rocketcpu_codec_init
// Walks the codec init table and writes each word to the codec SPI writer over
// a minimal Wishbone handshake, with a power-up settle delay, a fixed idle gap
// between words and a per-word ack timeout.
//   i_wb_clk  : clock (rising edge)
//   i_wb_rstn : synchronous active-low reset
//   i_start   : pulse to (re)run the table from word 0 when not busy
//   o_wb_cyc  : cycle request; o_wb_we mirrors it
//   o_wb_dat  : control word, zero whenever no cycle is active
//   i_wb_ack  : acknowledge from the SPI writer
//   o_busy    : sequence in progress
//   o_done    : sticky, all words acknowledged
//   o_error   : sticky, a word timed out
// -----------------------------------------------------------------------------
module rocketcpu_codec_init
    import rocketcpu_codec_pkg::*;
#(
    parameter int NWORDS         = DEFAULT_NWORDS,
    parameter int PWRUP_CYCLES   = 1024,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AUTOSTART      = 1
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rstn,
    input  logic        i_start,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [15:0] o_wb_dat,
    input  logic        i_wb_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int MAXCNT = (PWRUP_CYCLES > TIMEOUT_CYCLES)
                          ? ((PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES)
                          : ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES);
    localparam int CNTW   = $clog2(MAXCNT + 1);

    localparam logic [CNTW-1:0] PWRUP_LAST   = CNTW'(PWRUP_CYCLES - 1);
    localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
    // The LOAD cycle is also spent with cyc low, so the GAP state itself
    // lasts one cycle less than the total idle time between words.
    localparam logic [CNTW-1:0] GAP_LAST     = CNTW'(GAP_CYCLES - 2);
    localparam logic [IDXW-1:0] IDX_LAST     = IDXW'(NWORDS - 1);

    localparam codec_state_e RESET_STATE = (AUTOSTART != 0) ? ST_PWRUP : ST_IDLE;

    codec_state_e    state_q, state_d;
    logic [IDXW-1:0] index_q, index_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            cyc_q,   cyc_d;
    logic [15:0]     dat_q,   dat_d;
    logic            done_q,  done_d;
    logic            error_q, error_d;
    logic [15:0]     romWord;

    rocketcpu_codec_init_rom #(
        .NWORDS (NWORDS),
        .IDXW   (IDXW)
    ) u_rom (
        .index_i (index_q),
        .word_o  (romWord)
    );

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rstn) begin
            state_q <= RESET_STATE;
            index_q <= '0;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            dat_q   <= 16'h0000;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // One shared counter serves the power-up delay, the ack timeout and the
    // inter-word gap; it is cleared whenever a state that uses it is entered.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        dat_d   = dat_q;
        done_d  = done_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = '0;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d   = '0;
                    index_d = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_LOAD: begin
                // Data and cyc go up on the same edge so dat is never
                // visible without cyc.
                cyc_d   = 1'b1;
                dat_d   = romWord;
                cnt_d   = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Ack wins over a timeout expiring on the same edge.
                if (i_wb_ack) begin
                    cyc_d   = 1'b0;
                    dat_d   = 16'h0000;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cyc_d   = 1'b0;
                    dat_d   = 16'h0000;
                    error_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (index_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + IDXW'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign o_wb_cyc = cyc_q;
    assign o_wb_we  = cyc_q;
    assign o_wb_dat = dat_q;
    assign o_done   = done_q;
    assign o_error  = error_q;
    assign o_busy   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

endmodule

// File: tb/tb_rocketcpu_codec_init.sv
// -----------------------------------------------------------------------------
// tb_rocketcpu_codec_init
// Self-checking bench for rocketcpu_codec_init. A timeline model (next rise
// time, done time, word number) predicts cyc/we/dat/busy/done/error for every
// cycle; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_rocketcpu_codec_init;

    localparam int NW    = 11;
    localparam int PWRUP = 1024;
    localparam int GAP   = 4;
    localparam int TMO   = 4096;

    localparam logic [15:0] EXP_TABLE [NW] = '{
        16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0812, 16'h0A00, 16'h0E0A, 16'h1000, 16'h1201
    };

    logic        i_wb_clk  = 1'b0;
    logic        i_wb_rstn = 1'b0;
    logic        i_start   = 1'b0;
    logic        i_wb_ack  = 1'b0;
    logic        o_wb_cyc;
    logic        o_wb_we;
    logic [15:0] o_wb_dat;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    rocketcpu_codec_init #(
        .NWORDS         (NW),
        .PWRUP_CYCLES   (PWRUP),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .AUTOSTART      (1)
    ) dut (
        .i_wb_clk  (i_wb_clk),
        .i_wb_rstn (i_wb_rstn),
        .i_start   (i_start),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_we   (o_wb_we),
        .o_wb_dat  (o_wb_dat),
        .i_wb_ack  (i_wb_ack),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error)
    );

    always #5 i_wb_clk = ~i_wb_clk;

    // Slave model: acks a fixed or random number of cycles after cyc rises,
    // and optionally toggles ack at random while no cycle is open.
    int ackLatency     = 34;
    bit ackEnable      = 1'b1;
    bit randomLatency  = 1'b0;
    bit noiseEnable    = 1'b0;
    int highCnt        = 0;
    int curLat         = 34;

    always @(negedge i_wb_clk) begin
        if (o_wb_cyc) begin
            if (highCnt == 0) curLat = randomLatency ? int'($urandom_range(1, 60)) : ackLatency;
            highCnt++;
            i_wb_ack = ackEnable && (highCnt == curLat);
        end else begin
            highCnt  = 0;
            i_wb_ack = noiseEnable && ($urandom_range(0, 3) == 0);
        end
    end

    // Timeline model: each edge decides, from the inputs seen at that edge,
    // when the next word should start, when the run ends, or whether it fails.
    int cycleNo    = 0;
    bit mValid     = 1'b0;
    bit mCyc       = 1'b0;
    bit mDone      = 1'b0;
    bit mErr       = 1'b0;
    bit mBusy      = 1'b0;
    int mWord      = 0;
    int mRiseAt    = -1;
    int mDoneAt    = -1;
    int mHighSince = 0;
    bit startOk;

    always @(posedge i_wb_clk) begin
        cycleNo++;
        if (!i_wb_rstn) begin
            mValid  = 1'b1;
            mCyc    = 1'b0;
            mDone   = 1'b0;
            mErr    = 1'b0;
            mBusy   = 1'b1;
            mWord   = 0;
            mRiseAt = cycleNo + PWRUP + 1;
            mDoneAt = -1;
        end else if (mValid) begin
            if (mCyc) begin
                if (i_wb_ack) begin
                    mCyc = 1'b0;
                    if (mWord == NW - 1) begin
                        mDoneAt = cycleNo + GAP - 1;
                    end else begin
                        mWord   = mWord + 1;
                        mRiseAt = cycleNo + GAP;
                    end
                end else if (cycleNo - mHighSince == TMO) begin
                    mCyc  = 1'b0;
                    mErr  = 1'b1;
                    mBusy = 1'b0;
                end
            end else begin
                startOk = i_start && !mBusy;
                if (mDoneAt == cycleNo) begin
                    mDone   = 1'b1;
                    mBusy   = 1'b0;
                    mDoneAt = -1;
                end else if (mRiseAt == cycleNo) begin
                    mCyc       = 1'b1;
                    mHighSince = cycleNo;
                    mRiseAt    = -1;
                end
                if (startOk) begin
                    mDone   = 1'b0;
                    mErr    = 1'b0;
                    mWord   = 0;
                    mBusy   = 1'b1;
                    mRiseAt = cycleNo + 1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    int          pulseCount  = 0;
    int          runLen      = 0;
    int          lastHighLen = 0;
    bit          prevCyc     = 1'b0;
    int          lowLog [0:1023];
    logic [15:0] datLog [0:1023];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance one cycle, compare every output against the model, and log
    // pulse boundaries for the scenario-level checks.
    task automatic tick();
        logic [15:0] expDat;
        @(negedge i_wb_clk);
        if (mValid) begin
            expDat = (mCyc && mWord < NW) ? EXP_TABLE[mWord] : 16'h0000;
            checkOutput("cyc",   o_wb_cyc, mCyc);
            checkOutput("we",    o_wb_we,  mCyc);
            checkOutput("dat",   o_wb_dat, expDat);
            checkOutput("busy",  o_busy,   mBusy);
            checkOutput("done",  o_done,   mDone);
            checkOutput("error", o_error,  mErr);
        end
        if (o_wb_cyc !== prevCyc) begin
            if (o_wb_cyc) begin
                pulseCount++;
                lowLog[pulseCount & 1023] = runLen;
                datLog[pulseCount & 1023] = o_wb_dat;
            end else begin
                lastHighLen = runLen;
            end
            runLen = 1;
        end else begin
            runLen++;
        end
        prevCyc = o_wb_cyc;
    endtask

    task automatic applyStimulus(input bit startPulse, input bit resetPulse);
        if (startPulse) i_start = 1'b1;
        if (resetPulse) i_wb_rstn = 1'b0;
        tick();
        i_start   = 1'b0;
        i_wb_rstn = 1'b1;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (o_busy && n < bound) begin
            tick();
            n++;
        end
        if (o_busy) checkOutput("idle wait budget", o_busy, 1'b0);
    endtask

    task automatic measureRise(output int k, input int bound);
        k = 0;
        do begin
            tick();
            k++;
        end while (!o_wb_cyc && k < bound);
    endtask

    task automatic waitPulse(input int target, input int bound);
        int n = 0;
        bit ok;
        while (!(pulseCount >= target && o_wb_cyc) && n < bound) begin
            tick();
            n++;
        end
        ok = (pulseCount >= target) && o_wb_cyc;
        checkOutput("pulse wait", ok, 1'b1);
    endtask

    task automatic checkRun(input int base);
        checkOutput("pulse count", pulseCount - base, NW);
        for (int i = 1; i <= NW; i++) begin
            checkOutput("word order", datLog[(base + i) & 1023], EXP_TABLE[i - 1]);
            if (i > 1) checkOutput("gap length", lowLog[(base + i) & 1023], GAP);
        end
        checkOutput("last word", datLog[(base + NW) & 1023], 16'h1201);
        checkOutput("done at end", o_done, 1'b1);
        checkOutput("busy at end", o_busy, 1'b0);
        checkOutput("error at end", o_error, 1'b0);
    endtask

    initial begin
        int k;
        int base;

        // Reset and automatic power-up run with a 34-cycle slave.
        i_wb_rstn = 1'b0;
        repeat (3) tick();
        checkOutput("reset cyc",   o_wb_cyc, 1'b0);
        checkOutput("reset dat",   o_wb_dat, 16'h0000);
        checkOutput("reset done",  o_done,   1'b0);
        checkOutput("reset error", o_error,  1'b0);
        checkOutput("reset busy",  o_busy,   1'b1);
        i_wb_rstn = 1'b1;
        base = pulseCount;
        measureRise(k, 2000);
        checkOutput("first rise delay", k, 1025);
        checkOutput("first dat", o_wb_dat, 16'h1E00);
        waitIdle(3000);
        checkRun(base);

        // Restart from DONE with random ack latency and ack noise while idle.
        randomLatency = 1'b1;
        noiseEnable   = 1'b1;
        base = pulseCount;
        applyStimulus(1'b1, 1'b0);
        waitIdle(5000);
        checkRun(base);

        // Start pulse during word 5 must be ignored.
        randomLatency = 1'b0;
        noiseEnable   = 1'b0;
        base = pulseCount;
        applyStimulus(1'b1, 1'b0);
        waitPulse(base + 6, 1000);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0);
        waitIdle(3000);
        checkRun(base);

        // Slave never acks: timeout after 4096 WRITE cycles.
        ackEnable = 1'b0;
        base = pulseCount;
        applyStimulus(1'b1, 1'b0);
        waitIdle(6000);
        checkOutput("timeout high length", lastHighLen, TMO);
        checkOutput("timeout error", o_error, 1'b1);
        checkOutput("timeout done", o_done, 1'b0);
        checkOutput("timeout busy", o_busy, 1'b0);
        repeat (200) tick();
        checkOutput("pulses after error", pulseCount - base, 1);

        // Restart from ERROR: no power-up delay.
        ackEnable = 1'b1;
        base = pulseCount;
        applyStimulus(1'b1, 1'b0);
        checkOutput("error cleared", o_error, 1'b0);
        checkOutput("cyc in load", o_wb_cyc, 1'b0);
        tick();
        checkOutput("restart cyc", o_wb_cyc, 1'b1);
        checkOutput("restart dat", o_wb_dat, 16'h1E00);
        waitIdle(3000);
        checkRun(base);

        // One-cycle reset during word 3 WRITE.
        base = pulseCount;
        applyStimulus(1'b1, 1'b0);
        waitPulse(base + 4, 1000);
        repeat (5) tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid reset cyc",   o_wb_cyc, 1'b0);
        checkOutput("mid reset we",    o_wb_we,  1'b0);
        checkOutput("mid reset dat",   o_wb_dat, 16'h0000);
        checkOutput("mid reset done",  o_done,   1'b0);
        checkOutput("mid reset error", o_error,  1'b0);
        checkOutput("mid reset busy",  o_busy,   1'b1);
        base = pulseCount;
        measureRise(k, 2000);
        checkOutput("re-pwrup delay", k, 1025);
        checkOutput("re-pwrup dat", o_wb_dat, 16'h1E00);
        waitIdle(3000);
        checkRun(base);

        // Random runs with stray start pulses and one random reset.
        randomLatency = 1'b1;
        noiseEnable   = 1'b1;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 1'b0);
            repeat ($urandom_range(0, 400)) tick();
            applyStimulus(1'b1, r == 1);
            waitIdle(8000);
            repeat (10) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rocketcpu_codec_init.md
ROCKETCPU_CODEC_INIT -- requirements
Module: rocketcpu_codec_init

Interface
REQ-001 Parameter NWORDS, default 11: number of 16-bit codec control words in the init table.
REQ-002 Parameter PWRUP_CYCLES, default 1024: settle delay after reset before the first word.
REQ-003 Parameter GAP_CYCLES, default 4: idle cycles with o_wb_cyc low between words; legal range is 2 or more.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: maximum wait for i_wb_ack per word.
REQ-005 Parameter AUTOSTART, default 1: when 1, the sequence starts automatically after reset.
REQ-006 i_wb_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 i_wb_rstn  in  1  reset; synchronous, active-low.
REQ-008 i_start  in  1  single-cycle pulse that (re)runs the table from word 0.
REQ-009 o_wb_cyc  out  1  Wishbone cycle request to the codec SPI writer.
REQ-010 o_wb_we  out  1  write enable; always equal to o_wb_cyc.
REQ-011 o_wb_dat  out  16  control word {addr[6:0], data[8:0]}, MSB first.
REQ-012 i_wb_ack  in  1  acknowledge from the SPI writer.
REQ-013 o_busy  out  1  high in every state except IDLE, DONE and ERROR.
REQ-014 o_done  out  1  sticky high once all NWORDS words are acknowledged.
REQ-015 o_error  out  1  sticky high after an ack timeout.

Function
REQ-016 States shall be: IDLE, PWRUP, LOAD, WRITE, GAP, DONE and ERROR.
REQ-017 After reset, the FSM shall enter PWRUP if AUTOSTART=1, otherwise IDLE.
REQ-018 PWRUP shall count PWRUP_CYCLES cycles and then enter LOAD with index 0.
REQ-019 LOAD shall register o_wb_dat <= table[index], hold o_wb_cyc and o_wb_we low, and enter WRITE on the next edge.
REQ-020 WRITE shall drive o_wb_cyc=o_wb_we=1 with o_wb_dat stable until i_wb_ack is sampled high.
REQ-021 i_wb_ack shall be ignored while o_wb_cyc is low.
REQ-022 On ack, o_wb_cyc and o_wb_we shall drop on the next edge, and the FSM shall enter GAP.
REQ-023 GAP shall hold o_wb_cyc low for exactly GAP_CYCLES cycles, which lets the slave clear its bit counter and ack.
REQ-024 At the end of GAP: if index==NWORDS-1, enter DONE and set o_done; otherwise increment index and enter LOAD.
REQ-025 Ack latency shall be 0 cycles from ack to cyc deassert, registered; the slave's roughly 34-cycle serialization is not assumed.
REQ-026 In WRITE, a timeout counter shall reset on entry and increment each cycle.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES without ack: drop o_wb_cyc, set o_error, enter ERROR; the remaining words are skipped.
REQ-028 An ack arriving in the same cycle the timeout counter expires shall count as an ack (ack has priority).
REQ-029 i_start in IDLE, DONE or ERROR shall clear o_done and o_error, set index to 0, and enter LOAD with no PWRUP delay.
REQ-030 i_start while o_busy=1 shall be ignored.
REQ-031 The index width shall be clog2(NWORDS) with a minimum of 1; the index never wraps past NWORDS-1.
REQ-032 o_wb_dat shall be 16'h0000 whenever o_wb_cyc is low, except during the LOAD-to-WRITE edge.

Reset
REQ-033 On i_wb_rstn=0 at a clock edge: o_wb_cyc=0, o_wb_we=0, o_wb_dat=0, o_done=0, o_error=0, index=0 and counters=0.
REQ-034 The state on reset shall be PWRUP if AUTOSTART=1, otherwise IDLE.
REQ-035 Reset asserted mid-WRITE shall drop o_wb_cyc on that edge, with no completion of the current word.

Structure
REQ-036 A shared package rocketcpu_codec_pkg shall hold the state encoding, the control-word address constants (RESET=7'h0F, PWR=7'h06, IFACE=7'h07, SRATE=7'h08, ACTIVE=7'h09) and the default NWORDS.
REQ-037 One sub-module, rocketcpu_codec_init_rom, shall be a combinational table of NWORDS words indexed by index.
REQ-038 The ROM default table shall have word 0 = 16'h1E00 (codec reset) and the last word = 16'h1201 (active).
REQ-039 Everything else shall live in a single always block clocked by i_wb_clk.

Verification
REQ-040 Reset release, AUTOSTART=1, slave model acks 34 cycles after cyc rises -> first cyc rises 1025 cycles after reset release (PWRUP_CYCLES + LOAD), o_wb_dat=16'h1E00.
REQ-041 Full run with the same slave model -> exactly 11 cyc pulses, dat in table order, each gap 4 cycles low, last dat 16'h1201, o_done=1, o_busy=0.
REQ-042 Slave model never acks -> o_wb_cyc falls after 4096 WRITE cycles, o_error=1, o_done=0, and no further cyc pulses.
REQ-043 From ERROR, pulse i_start -> o_error clears, cyc rises 2 cycles later with dat 16'h1E00, and no PWRUP delay.
REQ-044 i_start pulsed during word 5 -> ignored; the sequence completes with exactly 11 words.
REQ-045 i_wb_rstn low for 1 cycle during word 3 WRITE -> cyc=0 on that edge, all outputs are at reset values, and PWRUP restarts from index 0.
